// File: rtl/vec_issue_seq.sv
// Vector issue sequencer: splits one vector op into 4-lane beats
// for the ALU pipes, with hold, flush and back-to-back issue.
module vec_issue_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_ins,
  input  logic [15:0] op_pc,
  input  logic [4:0]  op_len,
  input  logic        flush,
  input  logic        beat_hold,
  output logic        beat_valid,
  output logic [1:0]  beat_group,
  output logic [3:0]  beat_lane_en,
  output logic        beat_last,
  output logic [15:0] beat_ins,
  output logic [15:0] beat_pc,
  output logic        stall,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  group;
  logic [2:0]  nbeats;
  logic [4:0]  len;
  logic [15:0] ins;
  logic [15:0] pc;

  logic [4:0]  clen;
  logic [2:0]  nb_raw;
  logic [2:0]  nb_new;
  logic        is_last;
  logic        consume;
  logic        accept;

  assign clen   = (op_len > 5'd16) ? 5'd16 : op_len;
  assign nb_raw = clen[4:2] + {2'b00, |clen[1:0]};
  assign nb_new = (nb_raw == 3'd0) ? 3'd1 : nb_raw;

  assign busy    = (state == ISSUE);
  assign is_last = ({1'b0, group} == (nbeats - 3'd1));
  assign consume = busy && !beat_hold;

  assign op_ready = !flush &&
                    (!busy || (is_last && !beat_hold));
  assign accept   = op_valid && op_ready && !flush;
  assign stall    = op_valid && !op_ready;

  assign beat_valid = busy;
  assign beat_last  = busy && is_last;
  assign beat_group = group;
  assign beat_ins   = ins;
  assign beat_pc    = pc;

  // Lane i carries element 4*group+i; enabled while inside len.
  always_comb begin
    beat_lane_en = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      beat_lane_en[i] = ({1'b0, group, 2'(i)} < len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      group  <= 2'd0;
      nbeats <= 3'd0;
      len    <= 5'd0;
      ins    <= 16'd0;
      pc     <= 16'd0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state  <= ISSUE;
      group  <= 2'd0;
      nbeats <= nb_new;
      len    <= clen;
      ins    <= op_ins;
      pc     <= op_pc;
    end else if (consume) begin
      unique case (1'b1)
        is_last:  state <= IDLE;
        !is_last: group <= group + 2'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_seq.sv
// Randomised scoreboard bench for vec_issue_seq with a beat-list
// reference model and directed corner scenarios.
module tb_vec_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_ins;
  logic [15:0] op_pc;
  logic [4:0]  op_len;
  logic        flush;
  logic        beat_hold;
  logic        beat_valid;
  logic [1:0]  beat_group;
  logic [3:0]  beat_lane_en;
  logic        beat_last;
  logic [15:0] beat_ins;
  logic [15:0] beat_pc;
  logic        stall;
  logic        busy;

  always #5 clk = ~clk;

  vec_issue_seq dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_ins       (op_ins),
    .op_pc        (op_pc),
    .op_len       (op_len),
    .flush        (flush),
    .beat_hold    (beat_hold),
    .beat_valid   (beat_valid),
    .beat_group   (beat_group),
    .beat_lane_en (beat_lane_en),
    .beat_last    (beat_last),
    .beat_ins     (beat_ins),
    .beat_pc      (beat_pc),
    .stall        (stall),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0]  g;
    logic [3:0]  lane;
    logic        last;
    logic [15:0] ins;
    logic [15:0] pc;
  } beat_t;

  beat_t       q[$];
  beat_t       h;
  int          n_pass = 0;
  int          n_total = 0;
  bit          chk_en = 0;
  logic [1:0]  lg = '0;
  logic [3:0]  ll = '0;
  logic [15:0] li = '0;
  logic [15:0] lp = '0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  nm, got, exp, $time);
  endtask

  // Expected beats of one op, straight from the element-count rules.
  task automatic push_op(input logic [4:0] l,
                         input logic [15:0] ins,
                         input logic [15:0] pc);
    int el;
    int nb;
    beat_t b;
    el = (l > 16) ? 16 : int'(l);
    nb = (el == 0) ? 1 : (el + 3) / 4;
    for (int g = 0; g < nb; g++) begin
      b.g = 2'(g);
      for (int i = 0; i < 4; i++) b.lane[i] = (4 * g + i < el);
      b.last = (g == nb - 1);
      b.ins = ins;
      b.pc = pc;
      q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    logic exp_rdy;
    if (chk_en) begin
      exp_rdy = !flush &&
                (q.size() == 0 || (q.size() == 1 && !beat_hold));
      check("op_ready", 32'(op_ready), 32'(exp_rdy));
      check("stall", 32'(stall), 32'(op_valid && !exp_rdy));
      check("busy", 32'(busy), 32'(q.size() != 0));
      check("beat_valid", 32'(beat_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        h = q[0];
        check("group", 32'(beat_group), 32'(h.g));
        check("lane_en", 32'(beat_lane_en), 32'(h.lane));
        check("last", 32'(beat_last), 32'(h.last));
        check("ins", 32'(beat_ins), 32'(h.ins));
        check("pc", 32'(beat_pc), 32'(h.pc));
        lg = h.g; ll = h.lane; li = h.ins; lp = h.pc;
      end else begin
        check("idle_last", 32'(beat_last), 32'd0);
        check("idle_group", 32'(beat_group), 32'(lg));
        check("idle_lane", 32'(beat_lane_en), 32'(ll));
        check("idle_ins", 32'(beat_ins), 32'(li));
        check("idle_pc", 32'(beat_pc), 32'(lp));
      end
      // Model update for the coming posedge.
      if (rst) begin
        q.delete();
        lg = '0; ll = '0; li = '0; lp = '0;
      end else if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && !beat_hold) void'(q.pop_front());
        if (op_valid && exp_rdy) push_op(op_len, op_ins, op_pc);
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] l,
                       input logic [15:0] ins, input logic [15:0] pc,
                       input logic hd, input logic fl, input logic r);
    op_valid = v; op_len = l; op_ins = ins; op_pc = pc;
    beat_hold = hd; flush = fl; rst = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 5'd0, 16'h0, 16'h0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 5'd0, 16'h0, 16'h0, 0, 0, 1);
    chk_en = 1;
    drive(0, 5'd0, 16'h0, 16'h0, 0, 0, 1);
    idle(2);
    // len 7 with a second op waiting behind it
    drive(1, 5'd7, 16'hA123, 16'h0040, 0, 0, 0);
    drive(1, 5'd3, 16'hB000, 16'h0044, 0, 0, 0);
    drive(1, 5'd3, 16'hB000, 16'h0044, 0, 0, 0);
    idle(3);
    // back-to-back len 4 then len 12
    drive(1, 5'd4, 16'hC001, 16'h0100, 0, 0, 0);
    drive(1, 5'd12, 16'hC002, 16'h0104, 0, 0, 0);
    idle(5);
    // len 10 with a 3-cycle hold on g1
    drive(1, 5'd10, 16'hD00D, 16'h0200, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) drive(0, 5'd0, 16'h0, 16'h0, 1, 0, 0);
    idle(3);
    // flush during g1 of len 16 with a new op waiting
    drive(1, 5'd16, 16'hE0E0, 16'h0300, 0, 0, 0);
    idle(1);
    drive(1, 5'd3, 16'hE111, 16'h0304, 0, 1, 0);
    drive(1, 5'd3, 16'hE111, 16'h0304, 0, 0, 0);
    idle(3);
    // len 0 and clamped len 20
    drive(1, 5'd0, 16'hF000, 16'h0400, 0, 0, 0);
    idle(1);
    drive(1, 5'd20, 16'hF014, 16'h0404, 0, 0, 0);
    idle(5);
    // reset during g2 of len 16
    drive(1, 5'd16, 16'h1616, 16'h0500, 0, 0, 0);
    idle(2);
    drive(0, 5'd0, 16'h0, 16'h0, 0, 0, 1);
    idle(4);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 9) < 6, 5'($urandom),
            16'($urandom), 16'($urandom),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) == 0);
    end
    idle(6);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vec_issue_seq.md
VEC_ISSUE_SEQ -- requirements
Module: vec_issue_seq

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 op_valid  in  1  fetch-regs stage presents a vector op.
REQ-004 op_ready  out  1  sequencer accepts the op this cycle.
REQ-005 op_ins  in  16  instruction word, carried unchanged to beats.
REQ-006 op_pc  in  16  instruction PC, carried unchanged to beats.
REQ-007 op_len  in  5  vector length in elements; values 17..31 are clamped to 16.
REQ-008 flush  in  1  writeback jump flush.
REQ-009 beat_hold  in  1  downstream (coalesce) backpressure; current beat is not consumed.
REQ-010 beat_valid  out  1  a beat is presented to the 4 ALU pipes.
REQ-011 beat_group  out  2  element group g; lane i carries element 4g+i.
REQ-012 beat_lane_en  out  4  per-lane valid; bit i is set when 4g+i < len.
REQ-013 beat_last  out  1  final beat of the current op.
REQ-014 beat_ins / beat_pc  out  16 each  latched op_ins / op_pc.
REQ-015 stall  out  1  front-end stall; equals op_valid && !op_ready.
REQ-016 busy  out  1  high in state ISSUE.

Function
REQ-017 FSM states: IDLE and ISSUE; registers: state, group counter (2b), nbeats (3b), len (5b), ins, pc.
REQ-018 Accept condition: op_valid && op_ready && !flush.
REQ-019 op_ready = !flush && (state==IDLE || (beat_valid && beat_last && !beat_hold)); back-to-back ops are accepted with no bubble.
REQ-020 On accept, the sequencer latches clamped len, ins and pc, sets group=0, sets nbeats=max(1, ceil(len/4)), and enters ISSUE; the first beat is valid on the next cycle (1-cycle latency).
REQ-021 In ISSUE: beat_valid=1, beat_group=group, beat_last=(group==nbeats-1), lane_en per REQ-012, all derived from registers only.
REQ-022 A beat is consumed when beat_valid && !beat_hold; on a non-last consumed beat, group increments by 1.
REQ-023 With beat_hold=1, all beat outputs and registers hold unchanged.
REQ-024 On a consumed last beat: if accept occurs in the same cycle, reload per REQ-020 and stay in ISSUE; otherwise return to IDLE.
REQ-025 op_len=0 issues exactly one beat: group 0, lane_en=0000, beat_last=1.
REQ-026 op_len=16 issues 4 beats, all with lane_en=1111; op_len=5 issues 2 beats with lane_en 1111 then 0001.
REQ-027 Flush has priority over all other events: the next state is IDLE, beat_valid=0 on the next cycle, no accept occurs, and any in-progress op is discarded regardless of beat_hold.
REQ-028 An op is issued exactly once; an op is never partially re-issued after a hold.
REQ-029 In IDLE, beat_valid=0 and beat_last=0; beat_group, beat_lane_en, beat_ins and beat_pc hold their last values.

Reset
REQ-030 rst=1 at posedge: state=IDLE, group=0, nbeats=0, len=0, ins=0, pc=0; beat_valid=0, beat_last=0, beat_lane_en=0, busy=0.
REQ-031 rst has priority over flush and accept; rst asserted mid-op discards the op, and op_ready is high on the first cycle after rst deasserts.

Verification
REQ-032 op_len=7, ins=16'hA123, pc=16'h0040, no hold -> two beats on consecutive cycles: (g0, 1111, last=0), then (g1, 0111, last=1); beat_pc=0040 on both; stall high during the first beat if another op is waiting.
REQ-033 Back-to-back: op A len=4 followed immediately by op B len=12 -> beats A.g0(last), B.g0, B.g1, B.g2(last) with no idle cycle between ops.
REQ-034 op_len=10 with beat_hold=1 for 3 cycles on g1 -> g1 is presented for 4 cycles unchanged; g2 then follows with lane_en=0011 and last=1; total 3 beats consumed.
REQ-035 flush asserted during g1 of a len=16 op while op_valid=1 -> beat_valid=0 on the next cycle, op_ready=0 in the flush cycle, and the new op is accepted on the following cycle.
REQ-036 op_len=0 and op_len=20 -> a single beat (g0, 0000, last=1) for len 0; len 20 is treated as 16 (4 full beats).
REQ-037 rst pulsed during g2 of a len=16 op -> all outputs are at reset values on the next cycle, and no further beats of that op appear.
